// File: rtl/bellek_asamasi_pkg.sv
// Shared uop layout, memory-op encodings and exception codes
// for the memory stage and its load aligner.
package bellek_asamasi_pkg;

  localparam int PS_BIT       = 32;
  localparam int MXLEN        = 32;
  localparam int EXC_CODE_BIT = 4;
  localparam int UOP_BIT      = 101;

  typedef enum logic [3:0] {
    UOP_BELLEK_NOP = 4'd0,
    UOP_BELLEK_LB  = 4'd1,
    UOP_BELLEK_LH  = 4'd2,
    UOP_BELLEK_LW  = 4'd3,
    UOP_BELLEK_LBU = 4'd4,
    UOP_BELLEK_LHU = 4'd5,
    UOP_BELLEK_SB  = 4'd6,
    UOP_BELLEK_SH  = 4'd7,
    UOP_BELLEK_SW  = 4'd8
  } bellek_op_e;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] rd;
    logic [31:0] rs2;
    bellek_op_e  bellek;
    logic        valid;
  } uop_t;

  typedef enum logic [1:0] {
    BOSTA,
    ISTEK,
    YANIT
  } durum_e;

  localparam logic [EXC_CODE_BIT-1:0] EXC_CODE_LOAD_MISALIGN  = 4'd4;
  localparam logic [EXC_CODE_BIT-1:0] EXC_CODE_STORE_MISALIGN = 4'd6;

  function automatic logic yukleme_mi(bellek_op_e op);
    return op inside {UOP_BELLEK_LB, UOP_BELLEK_LH, UOP_BELLEK_LW,
                      UOP_BELLEK_LBU, UOP_BELLEK_LHU};
  endfunction

  function automatic logic saklama_mi(bellek_op_e op);
    return op inside {UOP_BELLEK_SB, UOP_BELLEK_SH, UOP_BELLEK_SW};
  endfunction

  function automatic logic hizasiz_mi(bellek_op_e op, logic [1:0] a);
    logic yarim;
    logic kelime;
    yarim  = op inside {UOP_BELLEK_LH, UOP_BELLEK_LHU, UOP_BELLEK_SH};
    kelime = op inside {UOP_BELLEK_LW, UOP_BELLEK_SW};
    return (yarim && a[0]) || (kelime && (a != 2'b00));
  endfunction

endpackage

// File: rtl/bellek_asamasi_yukleme_hizalayici.sv
// Load lane select and sign/zero extension of the read word.
// Halfword lane uses addr[1] only, word ignores the lane bits.
module yukleme_hizalayici
  import bellek_asamasi_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  serit_i,
  input  logic [31:0] veri_i,
  output logic [31:0] sonuc_o
);

  logic [7:0]  bayt;
  logic [15:0] yarim;

  always_comb begin
    bayt    = 8'(veri_i >> {serit_i, 3'b000});
    yarim   = serit_i[1] ? veri_i[31:16] : veri_i[15:0];
    sonuc_o = '0;
    unique case (1'b1)
      op_i == UOP_BELLEK_LB:  sonuc_o = {{24{bayt[7]}}, bayt};
      op_i == UOP_BELLEK_LBU: sonuc_o = {24'd0, bayt};
      op_i == UOP_BELLEK_LH:  sonuc_o = {{16{yarim[15]}}, yarim};
      op_i == UOP_BELLEK_LHU: sonuc_o = {16'd0, yarim};
      op_i == UOP_BELLEK_LW:  sonuc_o = veri_i;
      default:                sonuc_o = '0;
    endcase
  end

endmodule

// File: rtl/bellek_asamasi.sv
// Memory-access stage: single-outstanding load/store FSM.
// Define BELLEK_HIZASIZ_ISTISNA_EN to trap misaligned accesses.
module bellek_asamasi
  import bellek_asamasi_pkg::*;
#(
  parameter int VERI_BIT  = 32,
  parameter int ADRES_BIT = 32,
  parameter int MASKE_BIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [UOP_BIT-1:0]      bellek_uop_i,
  output logic                    duraklat_o,
  output logic                    veri_istek_o,
  input  logic                    veri_istek_hazir_i,
  output logic [ADRES_BIT-1:0]    veri_adres_o,
  output logic                    veri_yaz_o,
  output logic [MASKE_BIT-1:0]    veri_maske_o,
  output logic [VERI_BIT-1:0]     veri_yaz_veri_o,
  input  logic                    veri_yanit_gecerli_i,
  input  logic [VERI_BIT-1:0]     veri_yanit_veri_i,
  output logic [PS_BIT-1:0]       ddb_odd_ps_o,
  output logic [EXC_CODE_BIT-1:0] ddb_odd_kod_o,
  output logic [MXLEN-1:0]        ddb_odd_bilgi_o,
  output logic                    ddb_odd_gecerli_o,
  output logic [UOP_BIT-1:0]      geri_yaz_uop_o
);

  durum_e      durum_d, durum_q;
  uop_t        giris;
  uop_t        yakala_d, yakala_q;
  uop_t        cikis_d, cikis_q;
  logic        bellek_op;
  logic        hizasiz;
  logic        istek;
  logic        duraklat;
  logic [31:0] a_adres;
  logic [31:0] a_rs2;
  bellek_op_e  a_op;
  logic [3:0]  maske;
  logic [31:0] yaz_veri;
  logic [31:0] yuk_veri;

  assign giris     = uop_t'(bellek_uop_i);
  assign bellek_op = giris.valid && (giris.bellek != UOP_BELLEK_NOP);

  // Request fields come from the capture register once we leave BOSTA
  assign a_adres = (durum_q == BOSTA) ? giris.rd     : yakala_q.rd;
  assign a_rs2   = (durum_q == BOSTA) ? giris.rs2    : yakala_q.rs2;
  assign a_op    = (durum_q == BOSTA) ? giris.bellek : yakala_q.bellek;

  always_comb begin
    maske    = '0;
    yaz_veri = '0;
    unique case (1'b1)
      a_op == UOP_BELLEK_SB: begin
        maske    = 4'b0001 << a_adres[1:0];
        yaz_veri = {4{a_rs2[7:0]}};
      end
      a_op == UOP_BELLEK_SH: begin
        maske    = a_adres[1] ? 4'b1100 : 4'b0011;
        yaz_veri = {2{a_rs2[15:0]}};
      end
      a_op == UOP_BELLEK_SW: begin
        maske    = 4'b1111;
        yaz_veri = a_rs2;
      end
      default: begin
        maske    = '0;
        yaz_veri = '0;
      end
    endcase
  end

  yukleme_hizalayici u_hiza (
    .op_i    (yakala_q.bellek),
    .serit_i (yakala_q.rd[1:0]),
    .veri_i  (veri_yanit_veri_i),
    .sonuc_o (yuk_veri)
  );

`ifdef BELLEK_HIZASIZ_ISTISNA_EN
  logic                    odd_d, odd_q;
  logic [EXC_CODE_BIT-1:0] kod_d, kod_q;
  logic [PS_BIT-1:0]       ps_d, ps_q;
  logic [MXLEN-1:0]        bilgi_d, bilgi_q;

  assign hizasiz = hizasiz_mi(giris.bellek, giris.rd[1:0]);

  always_comb begin
    odd_d   = 1'b0;
    kod_d   = kod_q;
    ps_d    = ps_q;
    bilgi_d = bilgi_q;
    if (durum_q == BOSTA && bellek_op && hizasiz) begin
      odd_d   = 1'b1;
      kod_d   = yukleme_mi(giris.bellek) ? EXC_CODE_LOAD_MISALIGN
                                         : EXC_CODE_STORE_MISALIGN;
      ps_d    = giris.ps;
      bilgi_d = giris.rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      odd_q   <= 1'b0;
      kod_q   <= '0;
      ps_q    <= '0;
      bilgi_q <= '0;
    end else begin
      odd_q   <= odd_d;
      kod_q   <= kod_d;
      ps_q    <= ps_d;
      bilgi_q <= bilgi_d;
    end
  end

  assign ddb_odd_gecerli_o = odd_q;
  assign ddb_odd_kod_o     = kod_q;
  assign ddb_odd_ps_o      = ps_q;
  assign ddb_odd_bilgi_o   = bilgi_q;
`else
  assign hizasiz           = 1'b0;
  assign ddb_odd_gecerli_o = 1'b0;
  assign ddb_odd_kod_o     = '0;
  assign ddb_odd_ps_o      = '0;
  assign ddb_odd_bilgi_o   = '0;
`endif

  always_comb begin
    durum_d  = durum_q;
    yakala_d = yakala_q;
    cikis_d  = '0;
    istek    = 1'b0;
    duraklat = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        if (bellek_op && !hizasiz) begin
          istek    = 1'b1;
          duraklat = 1'b1;
          yakala_d = giris;
          durum_d  = veri_istek_hazir_i ? YANIT : ISTEK;
        end else begin
          cikis_d       = giris;
          cikis_d.valid = giris.valid && !hizasiz;
        end
      end
      ISTEK: begin
        istek    = 1'b1;
        duraklat = 1'b1;
        if (veri_istek_hazir_i) durum_d = YANIT;
      end
      YANIT: begin
        if (veri_yanit_gecerli_i) begin
          durum_d    = BOSTA;
          cikis_d    = yakala_q;
          cikis_d.rd = yukleme_mi(yakala_q.bellek) ? yuk_veri : '0;
        end else begin
          duraklat = 1'b1;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      durum_q  <= BOSTA;
      yakala_q <= '0;
      cikis_q  <= '0;
    end else begin
      durum_q  <= durum_d;
      yakala_q <= yakala_d;
      cikis_q  <= cikis_d;
    end
  end

  // Reset is synchronous, so mask the combinational handshake while held
  assign veri_istek_o    = istek && rstn_i;
  assign duraklat_o      = duraklat && rstn_i;
  assign veri_adres_o    = {a_adres[31:2], 2'b00};
  assign veri_yaz_o      = saklama_mi(a_op);
  assign veri_maske_o    = maske;
  assign veri_yaz_veri_o = yaz_veri;
  assign geri_yaz_uop_o  = cikis_q;

endmodule

// File: tb/tb_bellek_asamasi.sv
// Random + directed bench for bellek_asamasi against a
// transaction-level model of upstream, memory and writeback.
module tb_bellek_asamasi;
  import bellek_asamasi_pkg::*;

`ifdef BELLEK_HIZASIZ_ISTISNA_EN
  localparam bit HIZ_EN = 1'b1;
`else
  localparam bit HIZ_EN = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic [UOP_BIT-1:0] bellek_uop_i;
  logic               duraklat_o;
  logic               veri_istek_o;
  logic               veri_istek_hazir_i;
  logic [31:0]        veri_adres_o;
  logic               veri_yaz_o;
  logic [3:0]         veri_maske_o;
  logic [31:0]        veri_yaz_veri_o;
  logic               veri_yanit_gecerli_i;
  logic [31:0]        veri_yanit_veri_i;
  logic [31:0]        ddb_odd_ps_o;
  logic [3:0]         ddb_odd_kod_o;
  logic [31:0]        ddb_odd_bilgi_o;
  logic               ddb_odd_gecerli_o;
  logic [UOP_BIT-1:0] geri_yaz_uop_o;

  always #5 clk_i = ~clk_i;

  bellek_asamasi dut (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .bellek_uop_i         (bellek_uop_i),
    .duraklat_o           (duraklat_o),
    .veri_istek_o         (veri_istek_o),
    .veri_istek_hazir_i   (veri_istek_hazir_i),
    .veri_adres_o         (veri_adres_o),
    .veri_yaz_o           (veri_yaz_o),
    .veri_maske_o         (veri_maske_o),
    .veri_yaz_veri_o      (veri_yaz_veri_o),
    .veri_yanit_gecerli_i (veri_yanit_gecerli_i),
    .veri_yanit_veri_i    (veri_yanit_veri_i),
    .ddb_odd_ps_o         (ddb_odd_ps_o),
    .ddb_odd_kod_o        (ddb_odd_kod_o),
    .ddb_odd_bilgi_o      (ddb_odd_bilgi_o),
    .ddb_odd_gecerli_o    (ddb_odd_gecerli_o),
    .geri_yaz_uop_o       (geri_yaz_uop_o)
  );

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  task automatic kontrol(input string etiket,
                         input logic [127:0] gozlenen,
                         input logic [127:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got=%h exp=%h", etiket, gozlenen, beklenen);
    end
  endtask

  typedef struct {
    uop_t        u;
    logic [31:0] veri;
    int          tut;
  } yon_t;

  yon_t        yon_q[$];
  logic [31:0] sabit_q[$];

  uop_t        cur;
  bit          cur_yon;
  logic [31:0] cur_veri;
  int          hazir_tut;
  bit          kabul;
  int          gecikme;
  bit          yanit_simdi;
  bit          tuketildi;
  uop_t        bek_cikis;
  bit          bek_exc;
  logic [3:0]  bek_kod;
  logic [31:0] bek_ps;
  logic [31:0] bek_bilgi;

  function automatic bit m_yukleme(bellek_op_e op);
    return op inside {UOP_BELLEK_LB, UOP_BELLEK_LH, UOP_BELLEK_LW,
                      UOP_BELLEK_LBU, UOP_BELLEK_LHU};
  endfunction

  function automatic bit m_hizasiz(uop_t u);
    int a;
    a = int'(u.rd[1:0]);
    if (!HIZ_EN) return 1'b0;
    case (u.bellek)
      UOP_BELLEK_LH, UOP_BELLEK_LHU, UOP_BELLEK_SH: return (a % 2) != 0;
      UOP_BELLEK_LW, UOP_BELLEK_SW: return a != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_yukle(bellek_op_e op, logic [1:0] a,
                                          logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (op)
      UOP_BELLEK_LB:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      UOP_BELLEK_LBU: return b;
      UOP_BELLEK_LH:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      UOP_BELLEK_LHU: return h;
      default:        return w;
    endcase
  endfunction

  function automatic logic [3:0] m_maske(bellek_op_e op, logic [1:0] a);
    case (op)
      UOP_BELLEK_SB: return 4'(1 << a);
      UOP_BELLEK_SH: return 4'(3 << (a & 2'b10));
      UOP_BELLEK_SW: return 4'hF;
      default:       return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_veri(bellek_op_e op, logic [31:0] r);
    case (op)
      UOP_BELLEK_SB: return r[7:0] * 32'h0101_0101;
      UOP_BELLEK_SH: return r[15:0] * 32'h0001_0001;
      UOP_BELLEK_SW: return r;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic uop_t mk(bellek_op_e op, logic [31:0] rd,
                              logic [31:0] rs2);
    uop_t u;
    u.valid  = 1'b1;
    u.bellek = op;
    u.rd     = rd;
    u.rs2    = rs2;
    u.ps     = rd ^ 32'hA5A5_0000;
    return u;
  endfunction

  task automatic yeni_uop();
    yon_t y;
    if (yon_q.size() > 0) begin
      y         = yon_q.pop_front();
      cur       = y.u;
      cur_veri  = y.veri;
      hazir_tut = y.tut;
      cur_yon   = 1'b1;
    end else begin
      cur.valid  = ($urandom_range(0, 7) != 0);
      cur.bellek = bellek_op_e'($urandom_range(0, 8));
      cur.rd     = $urandom;
      cur.rs2    = $urandom;
      cur.ps     = $urandom;
      cur_veri   = 32'h0;
      hazir_tut  = 0;
      cur_yon    = 1'b0;
    end
    kabul = 1'b0;
  endtask

  task automatic cikis_kontrol();
    uop_t g;
    g = uop_t'(geri_yaz_uop_o);
    kontrol("cikis_gecerli", g.valid, bek_cikis.valid);
    if (bek_cikis.valid) begin
      kontrol("cikis_uop", g, bek_cikis);
      if (sabit_q.size() > 0) kontrol("sabit_rd", g.rd, sabit_q.pop_front());
    end
    kontrol("odd_gecerli", ddb_odd_gecerli_o, bek_exc);
    if (bek_exc) begin
      kontrol("odd_kod", ddb_odd_kod_o, bek_kod);
      kontrol("odd_ps", ddb_odd_ps_o, bek_ps);
      kontrol("odd_bilgi", ddb_odd_bilgi_o, bek_bilgi);
    end
  endtask

  task automatic cevrim();
    bit mem;
    bit mis;
    bit b_istek;
    bit b_dur;
    yanit_simdi          = 1'b0;
    veri_yanit_gecerli_i = 1'b0;
    veri_yanit_veri_i    = $urandom;
    if (kabul) begin
      if (gecikme == 0) begin
        yanit_simdi          = 1'b1;
        veri_yanit_gecerli_i = 1'b1;
        if (cur_yon) veri_yanit_veri_i = cur_veri;
      end else begin
        gecikme--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      veri_yanit_gecerli_i = 1'b1;
    end
    if (hazir_tut > 0) begin
      veri_istek_hazir_i = 1'b0;
      hazir_tut--;
    end else begin
      veri_istek_hazir_i = cur_yon ? 1'b1 : 1'($urandom_range(0, 1));
    end
    bellek_uop_i = cur;
    #4;
    mem     = cur.valid && (cur.bellek != UOP_BELLEK_NOP);
    mis     = mem && m_hizasiz(cur);
    b_istek = mem && !mis && !kabul;
    b_dur   = mem && !mis && !yanit_simdi;
    kontrol("duraklat", duraklat_o, b_dur);
    kontrol("istek", veri_istek_o, b_istek);
    if (b_istek) begin
      kontrol("adres", veri_adres_o, cur.rd & ~32'h3);
      kontrol("yaz", veri_yaz_o, !m_yukleme(cur.bellek));
      kontrol("maske", veri_maske_o, m_maske(cur.bellek, cur.rd[1:0]));
      kontrol("yaz_veri", veri_yaz_veri_o, m_veri(cur.bellek, cur.rs2));
    end
    if (b_istek && veri_istek_hazir_i) begin
      kabul   = 1'b1;
      gecikme = cur_yon ? 0 : int'($urandom_range(0, 2));
    end
    tuketildi = !b_dur;
    bek_cikis = '0;
    if (tuketildi) begin
      bek_cikis = cur;
      if (mis) bek_cikis.valid = 1'b0;
      else if (mem)
        bek_cikis.rd = m_yukleme(cur.bellek)
          ? m_yukle(cur.bellek, cur.rd[1:0], veri_yanit_veri_i) : 32'h0;
    end
    bek_exc = mis;
    if (mis) begin
      bek_kod   = m_yukleme(cur.bellek) ? 4'd4 : 4'd6;
      bek_ps    = cur.ps;
      bek_bilgi = cur.rd;
    end
    @(posedge clk_i);
    #1;
    cikis_kontrol();
    if (tuketildi) yeni_uop();
  endtask

  task automatic orta_sifirlama();
    int n;
    n = 0;
    while (!tuketildi && n < 20) begin
      cevrim();
      n++;
    end
    kontrol("rs_bosta_bekle", tuketildi, 1'b1);
    cur                  = mk(UOP_BELLEK_LW, 32'h300, 32'h0);
    bellek_uop_i         = cur;
    veri_istek_hazir_i   = 1'b1;
    veri_yanit_gecerli_i = 1'b0;
    #4;
    kontrol("rs_istek", veri_istek_o, 1'b1);
    @(posedge clk_i);
    #1;
    kontrol("rs_kabarcik", geri_yaz_uop_o[0], 1'b0);
    rstn_i = 1'b0;
    repeat (2) begin
      #4;
      kontrol("rs_istek0", veri_istek_o, 1'b0);
      kontrol("rs_dur0", duraklat_o, 1'b0);
      @(posedge clk_i);
      #1;
      kontrol("rs_cikis0", geri_yaz_uop_o, '0);
      kontrol("rs_odd0", ddb_odd_gecerli_o, 1'b0);
    end
    rstn_i               = 1'b1;
    cur                  = mk(UOP_BELLEK_NOP, 32'h77, 32'h5);
    bellek_uop_i         = cur;
    veri_yanit_gecerli_i = 1'b1;
    veri_yanit_veri_i    = 32'hCAFE_F00D;
    #4;
    kontrol("rs_bayat_dur", duraklat_o, 1'b0);
    kontrol("rs_bayat_istek", veri_istek_o, 1'b0);
    @(posedge clk_i);
    #1;
    kontrol("rs_add_gecis", geri_yaz_uop_o, cur);
    veri_yanit_gecerli_i = 1'b0;
    tuketildi            = 1'b1;
    yeni_uop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rstn_i               = 1'b0;
    bellek_uop_i         = mk(UOP_BELLEK_LW, 32'h40, 32'h0);
    veri_istek_hazir_i   = 1'b1;
    veri_yanit_gecerli_i = 1'b1;
    veri_yanit_veri_i    = 32'h1234_5678;
    @(posedge clk_i);
    #1;
    #4;
    kontrol("reset_istek", veri_istek_o, 1'b0);
    kontrol("reset_dur", duraklat_o, 1'b0);
    @(posedge clk_i);
    #1;
    kontrol("reset_cikis", geri_yaz_uop_o, '0);
    kontrol("reset_odd", ddb_odd_gecerli_o, 1'b0);

    yon_q.push_back('{mk(UOP_BELLEK_LW, 32'h100, 32'h0), 32'hDEAD_BEEF, 0});
    sabit_q.push_back(32'hDEAD_BEEF);
    yon_q.push_back('{mk(UOP_BELLEK_LB, 32'h103, 32'h0), 32'h80FF_FFFF, 0});
    sabit_q.push_back(32'hFFFF_FF80);
    yon_q.push_back('{mk(UOP_BELLEK_LBU, 32'h103, 32'h0), 32'h80FF_FFFF, 0});
    sabit_q.push_back(32'h0000_0080);
    yon_q.push_back('{mk(UOP_BELLEK_SH, 32'h102, 32'h1234_ABCD), 32'h0, 3});
    sabit_q.push_back(32'h0);
    yon_q.push_back('{mk(UOP_BELLEK_NOP, 32'h55, 32'h1), 32'h0, 0});
    sabit_q.push_back(32'h55);
    yon_q.push_back('{mk(UOP_BELLEK_LW, 32'h200, 32'h0), 32'h1111_1111, 0});
    sabit_q.push_back(32'h1111_1111);
    yon_q.push_back('{mk(UOP_BELLEK_LW, 32'h102, 32'h0), 32'h2222_3333, 0});

    rstn_i               = 1'b1;
    veri_yanit_gecerli_i = 1'b0;
    tuketildi            = 1'b1;
    bek_exc              = 1'b0;
    yeni_uop();
    repeat (40) cevrim();
    kontrol("sabit_bitti", 128'(sabit_q.size()), 128'd0);
    orta_sifirlama();
    repeat (3000) cevrim();

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
